wb_write_arbiter: RTL
=====================

Name: wb_write_arbiter

Overview:
- Writeback stage directly upstream of the integer register file.
- Collects results from NR_FU functional units over valid/ready handshakes.
- Arbitrates round-robin onto NR_WRITE_PORTS register-file write ports, one registered cycle ahead of the register file.
- Drops x0 writes and never issues two writes to the same register in one cycle.

Parameters:
- DATA_WIDTH, 32, width of the result data.
- NR_FU, 3, number of functional-unit result sources (2..8).
- NR_WRITE_PORTS, 2, number of register-file write ports (1..NR_FU).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; synchronous, active-low. One clock; all state is reset synchronously on clk_i when rst_ni=0.
- fu_valid_i  in  NR_FU  result valid, one bit per FU.
- fu_ready_o  out  NR_FU  result accepted this cycle (combinational).
- fu_waddr_i  in  NR_FU x 5  destination register per FU.
- fu_wdata_i  in  NR_FU x DATA_WIDTH  result data per FU.
- waddr_o  out  NR_WRITE_PORTS x 5  register-file write address (registered).
- wdata_o  out  NR_WRITE_PORTS x DATA_WIDTH  register-file write data (registered).
- we_o  out  NR_WRITE_PORTS  register-file write enable (registered).

Behaviour:
- Reset (rst_ni=0 at a clock edge): we_o=0, waddr_o=0, wdata_o=0, rr_q=0.
- While rst_ni=0, fu_ready_o=0 combinationally.
- Handshake:
  - A transfer occurs when fu_valid_i[i] & fu_ready_o[i].
  - A source holds valid, waddr and wdata stable until accepted.
  - fu_ready_o[i] is never asserted while fu_valid_i[i]=0.
- Arbitration, combinational, each cycle:
  - Scan FUs in order rr_q, rr_q+1, ... mod NR_FU.
  - Valid request with waddr=0: grant (ready=1) without consuming a port; no write is issued.
  - Valid request with nonzero waddr: grant if ports used < NR_WRITE_PORTS and waddr differs from every waddr already granted this cycle.
  - Otherwise the request waits: ready=0, no state change for it.
  - The k-th port-consuming grant in scan order is assigned to write port k. Unused ports get we=0.
- Output register: on each clock edge, waddr_o/wdata_o/we_o are loaded from the grant result.
  - Latency is exactly 1 cycle from acceptance to we_o.
  - When a port is unused: we_o=0, and waddr_o/wdata_o hold their previous values.
- Round-robin pointer:
  - If at least one port-consuming grant occurs, rr_q <= (index of last port-consuming grantee + 1) mod NR_FU.
  - Otherwise rr_q holds. x0-only grants do not move rr_q.
- Same-address conflict: the earlier FU in scan order wins. The later FU retries next cycle, where it is generally first in scan order.
- Starvation freedom: every valid request is granted within NR_FU cycles.
- No internal buffering beyond the output register. Backpressure comes only from port count and address conflicts.

Optional Feature:
- Macro WB_ARB_PERF_CNT_EN.
- When defined, add outputs:
  - perf_writes_o (32 bits): count of port-consuming grants, +k per cycle.
  - perf_conflicts_o (32 bits): count of cycles in which at least one valid request was refused because of a same-address conflict.
- Both counters wrap modulo 2^32 and reset to 0.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles with all fu_valid_i=1 -> fu_ready_o=0, we_o=0, waddr_o=0; first cycle after release grants FU0 and FU1.
- Single write: FU1 valid, waddr=5, wdata=0xDEAD_BEEF -> fu_ready_o=3'b010 same cycle; next cycle we_o[0]=1, waddr_o[0]=5, wdata_o[0]=0xDEAD_BEEF, we_o[1]=0.
- Port saturation: FU0/1/2 valid to regs 3/4/6, rr_q=0 -> cycle 1 grants FU0 (port0) and FU1 (port1), FU2 waits; cycle 2 grants FU2 on port0; rr_q goes 2 then 0.
- Address conflict: FU0 and FU1 both to reg 7 (0x11 and 0x22) -> FU0 granted first, we_o[0] with 0x11; FU1 granted next cycle with 0x22; perf_conflicts_o increments by 1 when the feature is enabled.
- x0 drop: FU0 to reg 0 and FU1 to reg 9, both valid -> both ready same cycle; next cycle exactly one write, waddr_o[0]=9; rr_q becomes 2.
- Fairness: all 3 FUs continuously valid to distinct regs for 30 cycles -> each FU accepted exactly 20 times, no FU waits more than 2 cycles; with WB_ARB_PERF_CNT_EN, perf_writes_o=60.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: round-robin merge of NR_FU result sources onto NR_WRITE_PORTS regfile write ports.
// Latency 1 cycle from acceptance to we_o; sources back-pressured only by port count and same-address conflicts.
// Optional perf counters (perf_writes_o, perf_conflicts_o) enabled by defining WB_ARB_PERF_CNT_EN.
module wb_write_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int NR_FU          = 3,
  parameter int NR_WRITE_PORTS = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NR_FU-1:0]                 fu_valid_i,
  output logic [NR_FU-1:0]                 fu_ready_o,
  input  logic [NR_FU*5-1:0]               fu_waddr_i,
  input  logic [NR_FU*DATA_WIDTH-1:0]      fu_wdata_i,
  output logic [NR_WRITE_PORTS*5-1:0]      waddr_o,
  output logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata_o,
  output logic [NR_WRITE_PORTS-1:0]        we_o
`ifdef WB_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                      perf_writes_o,
  output logic [31:0]                      perf_conflicts_o
`endif
);

  localparam int RR_W = (NR_FU > 1) ? $clog2(NR_FU) : 1;

  logic [RR_W-1:0]           rr_q;
  logic [RR_W-1:0]           rr_d;
  logic [NR_WRITE_PORTS-1:0] gnt_we;
  logic [4:0]                gnt_addr [NR_WRITE_PORTS];
  logic [DATA_WIDTH-1:0]     gnt_data [NR_WRITE_PORTS];
  logic [4:0]                req_addr;
  logic                      hit;
  int                        used;
`ifdef WB_ARB_PERF_CNT_EN
  logic                      conflict;
`endif

  always_comb begin
    fu_ready_o = '0;
    gnt_we     = '0;
    rr_d       = rr_q;
    used       = 0;
    hit        = 1'b0;
    req_addr   = '0;
    for (int p = 0; p < NR_WRITE_PORTS; p++) begin
      gnt_addr[p] = '0;
      gnt_data[p] = '0;
    end
`ifdef WB_ARB_PERF_CNT_EN
    conflict = 1'b0;
`endif
    // Visit sources in rotated order starting at rr_q; k-th visit serves FU (rr_q+k) mod NR_FU.
    for (int k = 0; k < NR_FU; k++) begin
      for (int i = 0; i < NR_FU; i++) begin
        if (i == (int'(rr_q) + k) % NR_FU && rst_ni && fu_valid_i[i]) begin
          req_addr = fu_waddr_i[i*5 +: 5];
          if (req_addr == 5'd0) begin
            fu_ready_o[i] = 1'b1;
          end else begin
            hit = 1'b0;
            for (int p = 0; p < NR_WRITE_PORTS; p++) begin
              if (p < used && gnt_addr[p] == req_addr) hit = 1'b1;
            end
`ifdef WB_ARB_PERF_CNT_EN
            if (hit) conflict = 1'b1;
`endif
            if (!hit && used < NR_WRITE_PORTS) begin
              for (int p = 0; p < NR_WRITE_PORTS; p++) begin
                if (p == used) begin
                  gnt_we[p]   = 1'b1;
                  gnt_addr[p] = req_addr;
                  gnt_data[p] = fu_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
              end
              fu_ready_o[i] = 1'b1;
              used          = used + 1;
              rr_d          = RR_W'((i + 1) % NR_FU);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q    <= '0;
      we_o    <= '0;
      waddr_o <= '0;
      wdata_o <= '0;
`ifdef WB_ARB_PERF_CNT_EN
      perf_writes_o    <= '0;
      perf_conflicts_o <= '0;
`endif
    end else begin
      rr_q <= rr_d;
      we_o <= gnt_we;
      // Idle ports keep their last address/data; only we_o drops.
      for (int p = 0; p < NR_WRITE_PORTS; p++) begin
        if (gnt_we[p]) begin
          waddr_o[p*5 +: 5]                   <= gnt_addr[p];
          wdata_o[p*DATA_WIDTH +: DATA_WIDTH] <= gnt_data[p];
        end
      end
`ifdef WB_ARB_PERF_CNT_EN
      perf_writes_o    <= perf_writes_o + $unsigned(used);
      perf_conflicts_o <= perf_conflicts_o + {31'd0, conflict};
`endif
    end
  end

endmodule
